// File: rtl/parking_time_tracker.sv
// ---------------------------------------------------------------------------
// parking_time_tracker
//
// Feeds the parking-duration subtractor stage. The block keeps a prescaled,
// free-running time counter and an entry timestamp for each slot. When a car
// leaves, it presents the slot's (entry, exit) timestamp pair downstream. The
// block also owns the slot occupancy bitmap and the full/empty flags.
//
// Duration arithmetic is not done here. The subtractor works modulo
// 2^TIME_W, so durations of 2^TIME_W units or more alias.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   car_in     in   entry request, sampled while req_ready=1
//   car_out    in   exit request, sampled while req_ready=1
//   slot_id    in   slot addressed by car_in/car_out
//   req_ready  out  a request can be accepted this cycle (IDLE)
//   time_in    out  entry timestamp of the exiting car
//   time_out   out  exit timestamp of the exiting car
//   pair_valid out  time_in/time_out are valid
//   pair_ready in   downstream accepts the pair
//   occupied   out  occupancy bitmap, bit i = slot i taken
//   full       out  every slot occupied
//   empty      out  no slot occupied
//   err        out  one-cycle pulse: the previous cycle's request was rejected
//   cur_time   out  current time counter
//
// Handshake: the pair transfers on a cycle where pair_valid and pair_ready
// are both high. While pair_valid is high, time_in and time_out stay stable.
// pair_valid is never withdrawn until that transfer happens. Requests are
// accepted only while req_ready=1. While a pair is pending, car_in and
// car_out are ignored and do not raise err.
// ---------------------------------------------------------------------------
module parking_time_tracker #(
  parameter int SLOTS    = 8,
  parameter int SLOT_W   = 3,
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              car_in,
  input  logic              car_out,
  input  logic [SLOT_W-1:0] slot_id,
  output logic              req_ready,
  output logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] time_out,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [SLOTS-1:0]  occupied,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [TIME_W-1:0] cur_time
);

  // When TICK_DIV=1 the prescaler is a single bit that stays at 0.
  // A tick then fires on every clock.
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  logic [TIME_W-1:0] stamp [SLOTS];

  logic slot_ok;
  logic slot_busy;
  logic any_req;
  logic entry_ok;
  logic exit_ok;
  logic reject;
  logic handshake;

  // -------------------------------------------------------------------------
  // Time base
  // -------------------------------------------------------------------------
  assign tick = (prescaler == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      cur_time  <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        // cur_time wraps naturally from 2^TIME_W-1 to 0.
        cur_time  <= cur_time + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  // slot_id can address past the last slot when SLOTS is not a power of two.
  // The bitmap lookup is masked by slot_ok, so an out-of-range index has no
  // effect.
  always_comb begin
    slot_ok   = (32'(slot_id) < 32'(SLOTS));
    slot_busy = 1'b0;
    if (slot_ok) begin
      slot_busy = occupied[slot_id];
    end
  end

  assign any_req   = car_in | car_out;
  assign entry_ok  = (state == IDLE) &&  car_in && !car_out && slot_ok && !slot_busy;
  assign exit_ok   = (state == IDLE) && !car_in &&  car_out && slot_ok &&  slot_busy;
  // Any request in IDLE that is not a clean entry or exit gets rejected.
  assign reject    = (state == IDLE) && any_req && !entry_ok && !exit_ok;
  assign handshake = pair_valid && pair_ready;

  // -------------------------------------------------------------------------
  // FSM: IDLE accepts requests; HOLD presents a pair until it is taken
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (exit_ok) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  // -------------------------------------------------------------------------
  // Occupancy bitmap and entry timestamps
  // -------------------------------------------------------------------------
  // A stamp takes cur_time as it is in the accepting cycle. If a tick lands
  // in that same cycle, the stamp holds the pre-increment value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        stamp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (entry_ok && (32'(slot_id) == 32'(i))) begin
          occupied[i] <= 1'b1;
          stamp[i]    <= cur_time;
        end else if (exit_ok && (32'(slot_id) == 32'(i))) begin
          occupied[i] <= 1'b0;
        end
      end
    end
  end

  assign full  = &occupied;
  assign empty = ~|occupied;

  // -------------------------------------------------------------------------
  // Output pair and error pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_in    <= '0;
      time_out   <= '0;
      pair_valid <= 1'b0;
    end else begin
      if (exit_ok) begin
        // exit_ok is only possible in IDLE, so this never overwrites a
        // pair that is still pending.
        time_in    <= stamp[slot_id];
        time_out   <= cur_time;
        pair_valid <= 1'b1;
      end else if (handshake) begin
        pair_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= reject;
    end
  end

endmodule

// File: tb/tb_parking_time_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for parking_time_tracker: directed scenarios with hand-computed
// expectations. A small time-base model supplies the current time unit, so
// the bench can tell when to issue each request.
// ---------------------------------------------------------------------------
module tb_parking_time_tracker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (SLOTS=8, TICK_DIV=4) ----------------
  logic       car_in = 1'b0, car_out = 1'b0, pair_ready = 1'b0;
  logic [2:0] slot_id = '0;
  logic       req_ready, pair_valid, full, empty, err;
  logic [7:0] time_in, time_out, cur_time, occupied;

  parking_time_tracker #(.SLOTS(8), .SLOT_W(3), .TIME_W(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .car_in(car_in), .car_out(car_out),
    .slot_id(slot_id), .req_ready(req_ready), .time_in(time_in),
    .time_out(time_out), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .occupied(occupied), .full(full), .empty(empty), .err(err),
    .cur_time(cur_time)
  );

  // ---------------- second DUT (SLOTS=6) for out-of-range slot ids --------
  logic       car_in2 = 1'b0, car_out2 = 1'b0, pair_ready2 = 1'b0;
  logic [2:0] slot_id2 = '0;
  logic       req_ready2, pair_valid2, full2, empty2, err2;
  logic [7:0] time_in2, time_out2, cur_time2;
  logic [5:0] occupied2;

  parking_time_tracker #(.SLOTS(6), .SLOT_W(3), .TIME_W(8), .TICK_DIV(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .car_in(car_in2), .car_out(car_out2),
    .slot_id(slot_id2), .req_ready(req_ready2), .time_in(time_in2),
    .time_out(time_out2), .pair_valid(pair_valid2), .pair_ready(pair_ready2),
    .occupied(occupied2), .full(full2), .empty(empty2), .err(err2),
    .cur_time(cur_time2)
  );

  // ---------------- time-base reference model ----------------
  logic [1:0] m_pre;
  logic [7:0] m_time;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre  <= 2'd0;
      m_time <= 8'd0;
    end else if (m_pre == 2'd3) begin
      m_pre  <= 2'd0;
      m_time <= m_time + 8'd1;
    end else begin
      m_pre  <= m_pre + 2'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_stamp [8];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Advance (at negedges) until the model shows time t; with need_tick the
  // prescaler must also be on its last count, so the next edge ticks.
  task automatic wait_time(input logic [7:0] t, input logic need_tick, input string tag);
    bit hit = 0;
    for (int n = 0; n < 1100; n++) begin
      if (m_time == t && (!need_tick || m_pre == 2'd3)) begin
        hit = 1;
        break;
      end
      step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s_wait: time %0d not reached, now %0d", tag, t, m_time);
    end
  endtask

  task automatic enter(input logic [2:0] s);
    car_in = 1'b1; slot_id = s;
    exp_stamp[s] = m_time;
    step();
    car_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    enter(3'd1);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (occupied !== 8'h00) begin errors++; $display("FAIL rst_async_occ: got %h exp 00", occupied); end
    checks++; if (cur_time !== 8'd0) begin errors++; $display("FAIL rst_async_time: got %0d exp 0", cur_time); end
    step();
    rst_n = 1'b1;
    checks++; if (cur_time !== 8'd0) begin errors++; $display("FAIL rst_time: got %0d exp 0", cur_time); end
    checks++; if (occupied !== 8'h00) begin errors++; $display("FAIL rst_occ: got %h exp 00", occupied); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", full); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", pair_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
    checks++; if ({time_in, time_out} !== 16'h0) begin errors++; $display("FAIL rst_pair: got %h exp 0000", {time_in, time_out}); end
  endtask

  task automatic test_basic();
    wait_time(8'd5, 1'b0, "basic_in");
    enter(3'd2);
    checks++; if (occupied !== 8'h04) begin errors++; $display("FAIL basic_occ_in: got %h exp 04", occupied); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b exp 0", empty); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", err); end
    wait_time(8'd12, 1'b0, "basic_out");
    car_out = 1'b1; slot_id = 3'd2;
    step();
    car_out = 1'b0;
    checks++; if (pair_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", pair_valid); end
    checks++; if (time_in !== 8'd5) begin errors++; $display("FAIL basic_time_in: got %0d exp 5", time_in); end
    checks++; if (time_out !== 8'd12) begin errors++; $display("FAIL basic_time_out: got %0d exp 12", time_out); end
    checks++; if (occupied !== 8'h00) begin errors++; $display("FAIL basic_occ_out: got %h exp 00", occupied); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready: got %b exp 0", req_ready); end
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b exp 0", pair_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    wait_time(8'd250, 1'b0, "wrap_in");
    enter(3'd0);
    wait_time(8'd4, 1'b0, "wrap_out");
    car_out = 1'b1; slot_id = 3'd0;
    step();
    car_out = 1'b0;
    d = time_out - time_in;
    checks++; if (time_in !== 8'd250) begin errors++; $display("FAIL wrap_time_in: got %0d exp 250", time_in); end
    checks++; if (time_out !== 8'd4) begin errors++; $display("FAIL wrap_time_out: got %0d exp 4", time_out); end
    checks++; if (d !== 8'd10) begin errors++; $display("FAIL wrap_duration: got %0d exp 10", d); end
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] t_out;
    enter(3'd1);
    car_out = 1'b1; slot_id = 3'd1;
    t_out = m_time;
    step();
    car_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      car_in = (i % 2 == 0); slot_id = 3'd4;
      step();
      checks++; if (pair_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, pair_valid); end
      checks++; if (time_in !== exp_stamp[1] || time_out !== t_out) begin errors++; $display("FAIL bp_pair[%0d]: got %0d/%0d exp %0d/%0d", i, time_in, time_out, exp_stamp[1], t_out); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, req_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err[%0d]: got %b exp 0", i, err); end
      checks++; if (occupied !== 8'h00) begin errors++; $display("FAIL bp_occ[%0d]: got %h exp 00", i, occupied); end
    end
    car_in = 1'b0;
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b exp 0", pair_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b exp 1", req_ready); end
  endtask

  task automatic test_errors();
    enter(3'd3);
    checks++; if (occupied !== 8'h08) begin errors++; $display("FAIL err_setup_occ: got %h exp 08", occupied); end
    // entry to occupied slot 3
    car_in = 1'b1; slot_id = 3'd3;
    step();
    car_in = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_dup_entry: got %b exp 1", err); end
    checks++; if (occupied !== 8'h08) begin errors++; $display("FAIL err_dup_occ: got %h exp 08", occupied); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %b exp 0", err); end
    // exit from free slot 5
    car_out = 1'b1; slot_id = 3'd5;
    step();
    car_out = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_free_exit: got %b exp 1", err); end
    checks++; if (pair_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL err_free_state: got valid %b ready %b exp 0 1", pair_valid, req_ready); end
    // both requests at once
    car_in = 1'b1; car_out = 1'b1; slot_id = 3'd6;
    step();
    car_in = 1'b0; car_out = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_both: got %b exp 1", err); end
    checks++; if (occupied !== 8'h08) begin errors++; $display("FAIL err_both_occ: got %h exp 08", occupied); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_both_len: got %b exp 0", err); end
    // slot_id == SLOTS on the 6-slot instance
    car_in2 = 1'b1; slot_id2 = 3'd6;
    step();
    car_in2 = 1'b0;
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL err_range: got %b exp 1", err2); end
    checks++; if (occupied2 !== 6'h00) begin errors++; $display("FAIL err_range_occ: got %h exp 00", occupied2); end
    // last legal slot on the 6-slot instance
    car_in2 = 1'b1; slot_id2 = 3'd5;
    step();
    car_in2 = 1'b0;
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL range_last_err: got %b exp 0", err2); end
    checks++; if (occupied2 !== 6'h20) begin errors++; $display("FAIL range_last_occ: got %h exp 20", occupied2); end
  endtask

  task automatic test_capacity();
    logic [7:0] exp_occ;
    exp_occ = 8'h08;
    for (int s = 0; s < 8; s++) begin
      if (s != 3) begin
        enter(3'(s));
        exp_occ[s] = 1'b1;
        checks++; if (occupied !== exp_occ) begin errors++; $display("FAIL cap_fill[%0d]: got %h exp %h", s, occupied, exp_occ); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL cap_full: got %b exp 1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL cap_empty: got %b exp 0", empty); end
    car_in = 1'b1; slot_id = 3'd0;
    step();
    car_in = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cap_ninth: got %b exp 1", err); end
    checks++; if (occupied !== 8'hff) begin errors++; $display("FAIL cap_ninth_occ: got %h exp ff", occupied); end
  endtask

  task automatic test_tick_exit();
    wait_time(8'd7, 1'b1, "tick");
    car_out = 1'b1; slot_id = 3'd7;
    step();
    car_out = 1'b0;
    checks++; if (time_out !== 8'd7) begin errors++; $display("FAIL tick_time_out: got %0d exp 7", time_out); end
    checks++; if (cur_time !== 8'd8) begin errors++; $display("FAIL tick_cur_time: got %0d exp 8", cur_time); end
    checks++; if (time_in !== exp_stamp[7]) begin errors++; $display("FAIL tick_time_in: got %0d exp %0d", time_in, exp_stamp[7]); end
    checks++; if (full !== 1'b0 || occupied !== 8'h7f) begin errors++; $display("FAIL tick_occ: got %h full %b exp 7f 0", occupied, full); end
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] t_out;
    pair_ready = 1'b1;
    car_out = 1'b1; slot_id = 3'd6;
    step();
    checks++; if (pair_valid !== 1'b1 || time_in !== exp_stamp[6]) begin errors++; $display("FAIL b2b_first: got valid %b in %0d exp 1 %0d", pair_valid, time_in, exp_stamp[6]); end
    slot_id = 3'd5;
    step();
    checks++; if (pair_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got valid %b ready %b exp 0 1", pair_valid, req_ready); end
    checks++; if (occupied !== 8'h3f || err !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got occ %h err %b exp 3f 0", occupied, err); end
    t_out = m_time;
    step();
    car_out = 1'b0;
    checks++; if (pair_valid !== 1'b1 || time_in !== exp_stamp[5] || time_out !== t_out) begin errors++; $display("FAIL b2b_second: got %b %0d/%0d exp 1 %0d/%0d", pair_valid, time_in, time_out, exp_stamp[5], t_out); end
    checks++; if (occupied !== 8'h1f) begin errors++; $display("FAIL b2b_occ: got %h exp 1f", occupied); end
    step();
    pair_ready = 1'b0;
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b exp 0", pair_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 8; i++) exp_stamp[i] = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_errors();
    test_capacity();
    test_tick_exit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
